// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU with an optional iterative restoring divider
// The divider (DIV state) is built only when ALU_SEQ_DIV_EN is defined.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [3:0]           ALU_FUN,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [2*WIDTH-1:0]   ALU_OUT,
  output logic                 CARRY_OUT,
  output logic [3:0]           FLAGS,
  output logic                 DIV_BY_ZERO
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
`ifdef ALU_SEQ_DIV_EN
    S_DIV,
`endif
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic [W2-1:0]    res_q, res_c;
  logic             carry_q, carry_c;
  logic [3:0]       flags_q, flags_c;
  logic             dbz_q, dbz_c;
  logic [WIDTH:0]   sum;

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH-1:0] rem_q, quo_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   shifted, trial;
  logic             fits;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, b_q};
  assign fits    = shifted >= {1'b0, b_q};
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (IN_VALID) begin
`ifdef ALU_SEQ_DIV_EN
          if (ALU_FUN == 4'b0011) state_nxt = (B == '0) ? S_DONE : S_DIV;
          else                    state_nxt = S_EXEC;
`else
          state_nxt = S_EXEC;
`endif
        end
      end
      S_EXEC: state_nxt = S_DONE;
`ifdef ALU_SEQ_DIV_EN
      S_DIV:  if (cnt_q == CW'(WIDTH)) state_nxt = S_DONE;
`endif
      S_DONE: if (OUT_READY) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    dbz_c   = 1'b0;
    case (op_q)
      4'b0000: begin res_c[WIDTH:0] = sum; carry_c = sum[WIDTH]; end
      4'b0001: begin res_c[WIDTH-1:0] = a_q - b_q; carry_c = a_q < b_q; end
      4'b0010: res_c = W2'(a_q) * W2'(b_q);
      4'b0011: dbz_c = 1'b1;
      4'b0100: res_c[WIDTH-1:0] = a_q & b_q;
      4'b0101: res_c[WIDTH-1:0] = a_q | b_q;
      4'b0110: res_c[WIDTH-1:0] = ~(a_q & b_q);
      4'b0111: res_c[WIDTH-1:0] = ~(a_q | b_q);
      4'b1001: res_c[1:0] = (a_q == b_q) ? 2'd1 : 2'd0;
      4'b1010: res_c[1:0] = (a_q > b_q)  ? 2'd2 : 2'd0;
      4'b1011: res_c[1:0] = (a_q < b_q)  ? 2'd3 : 2'd0;
      4'b1100: res_c[WIDTH-1:0] = a_q >> 1;
      4'b1101: res_c[WIDTH:0]   = {a_q, 1'b0};
      4'b1110: res_c[WIDTH-1:0] = b_q >> 1;
      4'b1111: res_c[WIDTH:0]   = {b_q, 1'b0};
      default: ;
    endcase
    flags_c = 4'b0001 << op_q[3:2];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      flags_q <= '0;
      dbz_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (IN_VALID) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= ALU_FUN;
`ifdef ALU_SEQ_DIV_EN
            if (ALU_FUN == 4'b0011) begin
              if (B == '0) begin
                res_q   <= {A, {WIDTH{1'b1}}};
                carry_q <= 1'b0;
                flags_q <= 4'b0001;
                dbz_q   <= 1'b1;
              end else begin
                rem_q <= '0;
                quo_q <= A;
                cnt_q <= '0;
              end
            end
`endif
          end
        end
        S_EXEC: begin
          res_q   <= res_c;
          carry_q <= carry_c;
          flags_q <= flags_c;
          dbz_q   <= dbz_c;
        end
`ifdef ALU_SEQ_DIV_EN
        // WIDTH iteration cycles, then one cycle to publish {remainder, quotient}.
        S_DIV: begin
          if (cnt_q == CW'(WIDTH)) begin
            res_q   <= {rem_q, quo_q};
            carry_q <= 1'b0;
            flags_q <= 4'b0001;
            dbz_q   <= 1'b0;
          end else begin
            rem_q <= fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], fits};
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign IN_READY    = (state == S_IDLE);
  assign OUT_VALID   = (state == S_DONE);
  assign ALU_OUT     = res_q;
  assign CARRY_OUT   = carry_q;
  assign FLAGS       = flags_q;
  assign DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH=16), honours ALU_SEQ_DIV_EN
module tb_alu_seq;

  logic        CLK, RST;
  logic [15:0] A, B;
  logic [3:0]  ALU_FUN;
  logic        IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [31:0] ALU_OUT;
  logic        CARRY_OUT, DIV_BY_ZERO;
  logic [3:0]  FLAGS;

  int errors = 0;
  int checks = 0;

  alu_seq #(.WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .ALU_OUT(ALU_OUT), .CARRY_OUT(CARRY_OUT),
    .FLAGS(FLAGS), .DIV_BY_ZERO(DIV_BY_ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    bit [31:0] res;
    bit        c;
    bit [3:0]  fl;
    bit        dz;
    int        lat;
  } exp_t;

  // Reference: plain integer arithmetic on the architectural rules.
  function automatic exp_t model(bit [15:0] a, bit [15:0] b, bit [3:0] op);
    exp_t e;
    int unsigned ua = a;
    int unsigned ub = b;
    bit [1:0] unit = op[3:2];
    e.res = 0; e.c = 0; e.dz = 0; e.lat = 2;
    e.fl = 4'(1 << unit);
    case (op)
      4'd0:  begin e.res = ua + ub; e.c = (ua + ub) > 32'd65535; end
      4'd1:  begin e.res = (ua - ub) & 32'hFFFF; e.c = ua < ub; end
      4'd2:  e.res = ua * ub;
      4'd3: begin
`ifdef ALU_SEQ_DIV_EN
        if (ub == 0) begin e.res = (ua << 16) | 32'hFFFF; e.dz = 1; e.lat = 1; end
        else begin e.res = ((ua % ub) << 16) | (ua / ub); e.lat = 18; end
`else
        e.dz = 1;
`endif
      end
      4'd4:  e.res = ua & ub;
      4'd5:  e.res = ua | ub;
      4'd6:  e.res = ~(ua & ub) & 32'hFFFF;
      4'd7:  e.res = ~(ua | ub) & 32'hFFFF;
      4'd8:  e.res = 0;
      4'd9:  e.res = (ua == ub) ? 1 : 0;
      4'd10: e.res = (ua > ub) ? 2 : 0;
      4'd11: e.res = (ua < ub) ? 3 : 0;
      4'd12: e.res = ua >> 1;
      4'd13: e.res = (ua << 1) & 32'h1FFFF;
      4'd14: e.res = ub >> 1;
      default: e.res = (ub << 1) & 32'h1FFFF;
    endcase
    return e;
  endfunction

  // Drives one request from a negedge; returns the sampled result and
  // the edge count (accept edge = 1) at which OUT_VALID was first seen.
  task automatic issue(input bit [15:0] a, input bit [15:0] b, input bit [3:0] op,
                       output int lat, output logic [31:0] res, output logic c,
                       output logic [3:0] fl, output logic dz);
    int guard = 0;
    while (!IN_READY && guard < 50) begin @(negedge CLK); guard++; end
    A = a; B = b; ALU_FUN = op; IN_VALID = 1'b1;
    @(posedge CLK);
    lat = 1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    A = 16'($urandom); B = 16'($urandom); ALU_FUN = 4'($urandom);
    while (!OUT_VALID && lat < 100) begin @(posedge CLK); lat++; @(negedge CLK); end
    res = ALU_OUT; c = CARRY_OUT; fl = FLAGS; dz = DIV_BY_ZERO;
  endtask

  task automatic retire();
    OUT_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; A = '0; B = '0; ALU_FUN = '0;
    repeat (2) @(negedge CLK);
    checks++; if (ALU_OUT !== 32'h0) begin errors++; $display("FAIL reset_out got=%h exp=0", ALU_OUT); end
    checks++; if ({OUT_VALID, CARRY_OUT, DIV_BY_ZERO, FLAGS} !== 7'b0)
      begin errors++; $display("FAIL reset_flags got=%b exp=0", {OUT_VALID, CARRY_OUT, DIV_BY_ZERO, FLAGS}); end
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", IN_READY); end
  endtask

  task automatic test_directed();
    int lat; logic [31:0] r; logic c, dz; logic [3:0] fl;
    issue(16'hFFFF, 16'h0001, 4'b0000, lat, r, c, fl, dz);
    checks++; if (lat !== 2) begin errors++; $display("FAIL add_lat got=%0d exp=2", lat); end
    checks++; if ({r, c, fl} !== {32'h0001_0000, 1'b1, 4'b0001})
      begin errors++; $display("FAIL add_carry got=%h/%b/%b exp=00010000/1/0001", r, c, fl); end
    retire();
    issue(16'h801A, 16'h0000, 4'b1101, lat, r, c, fl, dz);
    checks++; if ({r, fl} !== {32'h0001_0034, 4'b1000})
      begin errors++; $display("FAIL shl got=%h/%b exp=00010034/1000", r, fl); end
    retire();
    issue(16'h000A, 16'h000F, 4'b0110, lat, r, c, fl, dz);
    checks++; if ({r, fl, c} !== {32'h0000_FFF5, 4'b0010, 1'b0})
      begin errors++; $display("FAIL nand got=%h/%b/%b exp=0000fff5/0010/0", r, fl, c); end
    retire();
`ifdef ALU_SEQ_DIV_EN
    issue(16'd500, 16'd10, 4'b0011, lat, r, c, fl, dz);
    checks++; if (lat !== 18) begin errors++; $display("FAIL div_lat got=%0d exp=18", lat); end
    checks++; if ({r, dz, fl} !== {32'd50, 1'b0, 4'b0001})
      begin errors++; $display("FAIL div_res got=%h/%b/%b exp=00000032/0/0001", r, dz, fl); end
    retire();
    issue(16'd7, 16'd0, 4'b0011, lat, r, c, fl, dz);
    checks++; if ({r, dz} !== {32'h0007_FFFF, 1'b1})
      begin errors++; $display("FAIL div0 got=%h/%b exp=0007ffff/1", r, dz); end
    retire();
`else
    issue(16'd500, 16'd10, 4'b0011, lat, r, c, fl, dz);
    checks++; if (lat !== 2) begin errors++; $display("FAIL nodiv_lat got=%0d exp=2", lat); end
    checks++; if ({r, dz, fl} !== {32'h0, 1'b1, 4'b0001})
      begin errors++; $display("FAIL nodiv_res got=%h/%b/%b exp=0/1/0001", r, dz, fl); end
    retire();
`endif
    checks++; if ({OUT_VALID, IN_READY} !== 2'b01)
      begin errors++; $display("FAIL retire_state got=%b exp=01", {OUT_VALID, IN_READY}); end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] r; logic c, dz; logic [3:0] fl;
    issue(16'd9, 16'd10, 4'b1011, lat, r, c, fl, dz);
    checks++; if ({r, fl} !== {32'd3, 4'b0100})
      begin errors++; $display("FAIL bp_res got=%h/%b exp=3/0100", r, fl); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin A = 16'd1; B = 16'd1; ALU_FUN = 4'b0000; IN_VALID = 1'b1; end
      else IN_VALID = 1'b0;
      @(negedge CLK);
      checks++; if ({ALU_OUT, IN_READY, OUT_VALID} !== {32'd3, 1'b0, 1'b1})
        begin errors++; $display("FAIL bp_hold cyc=%0d got=%h/%b/%b exp=3/0/1", i, ALU_OUT, IN_READY, OUT_VALID); end
    end
    IN_VALID = 1'b0;
    retire();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (OUT_VALID !== 1'b0)
        begin errors++; $display("FAIL bp_no_queue cyc=%0d got=%b exp=0", i, OUT_VALID); end
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [31:0] r; logic c, dz; logic [3:0] fl;
`ifdef ALU_SEQ_DIV_EN
    int wait_edges = 8;
    A = 16'd500; B = 16'd10; ALU_FUN = 4'b0011;
`else
    int wait_edges = 1;
    A = 16'd300; B = 16'd7; ALU_FUN = 4'b0010;
`endif
    IN_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (wait_edges) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    checks++; if ({ALU_OUT, OUT_VALID, CARRY_OUT, DIV_BY_ZERO, FLAGS} !== 39'b0)
      begin errors++; $display("FAIL rst_async got=%h/%b/%b/%b/%b exp=0", ALU_OUT, OUT_VALID, CARRY_OUT, DIV_BY_ZERO, FLAGS); end
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", IN_READY); end
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      checks++; if (OUT_VALID !== 1'b0)
        begin errors++; $display("FAIL rst_discard cyc=%0d got=%b exp=0", i, OUT_VALID); end
    end
    issue(16'd10, 16'd10, 4'b1001, lat, r, c, fl, dz);
    checks++; if ({lat, r, fl} !== {32'd2, 32'd1, 4'b0100})
      begin errors++; $display("FAIL rst_after got=%0d/%h/%b exp=2/1/0100", lat, r, fl); end
    retire();
  endtask

  task automatic test_random();
    int lat; logic [31:0] r; logic c, dz; logic [3:0] fl;
    exp_t e;
    bit [15:0] a, b;
    bit [3:0] op;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(3))
        0: a = 16'hFFFF;
        1: a = 16'($urandom_range(3));
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(4))
        0: b = 16'h0000;
        1: b = a;
        2: b = 16'hFFFF;
        default: b = 16'($urandom);
      endcase
      op = (n < 16) ? 4'(n) : 4'($urandom);
      e = model(a, b, op);
      issue(a, b, op, lat, r, c, fl, dz);
      checks++; if (lat !== e.lat)
        begin errors++; $display("FAIL rand_lat op=%h a=%h b=%h got=%0d exp=%0d", op, a, b, lat, e.lat); end
      checks++; if ({r, c, fl, dz} !== {e.res, e.c, e.fl, e.dz})
        begin errors++; $display("FAIL rand_res op=%h a=%h b=%h got=%h/%b/%b/%b exp=%h/%b/%b/%b",
                                 op, a, b, r, c, fl, dz, e.res, e.c, e.fl, e.dz); end
      repeat ($urandom_range(3)) @(negedge CLK);
      checks++; if ({ALU_OUT, OUT_VALID} !== {e.res, 1'b1})
        begin errors++; $display("FAIL rand_hold op=%h got=%h/%b exp=%h/1", op, ALU_OUT, OUT_VALID, e.res); end
      retire();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
